// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared definitions for the pipeline run/step/halt sequencer:
// halt opcode default, command encodings and sequencer state encodings.
package pipeline_exec_ctrl_pkg;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'h3F;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_HALT = 2'b11   // HALT in RUN, CLEAR in IDLE/HALTED
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // States in which the pipeline registers advance.
    function automatic logic is_enabled_state(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter: clears on reset or clr, increments on inc,
// and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Clear has priority over increment; hold at all-ones.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline. Gates the pipeline and
// PC enables, detects the halt word at IF, drains in-flight instructions,
// parks the core and counts enabled cycles.
//
// Command handshake: a command transfers on a clock edge where
// cmd_valid && cmd_ready. cmd_ready depends only on the current state
// (high in IDLE, RUN, HALTED). When cmd_ready is low the command is not
// consumed and the source must keep cmd_valid/cmd_op stable.
module pipeline_exec_ctrl
    import pipeline_exec_ctrl_pkg::*;
#(
    parameter int         CYCLE_W      = 32,
    parameter int         DRAIN_CYCLES = 4,
    parameter logic [5:0] HALT_OPCODE  = HALT_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [31:0]        instr_IF,
    output logic               pipe_en,
    output logic               pc_en,
    output logic               pipe_reset,
    output logic               busy,
    output logic               halted,
    output logic               done_pulse,
    output logic [CYCLE_W-1:0] cycle_count,
    output state_t             dbg_state
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          pipe_reset_nxt;
    logic          hit;
    logic          cmd_acc;
    cmd_op_t       op;
    logic          unused_instr_bits;

    assign unused_instr_bits = ^instr_IF[25:0];
    assign dbg_state         = state;

    // Enables and ready are decoded straight from the current state.
    always_comb begin
        hit       = (instr_IF[31:26] == HALT_OPCODE);
        pipe_en   = is_enabled_state(state);
        pc_en     = pipe_en && !hit && (state != ST_DRAIN);
        cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALTED);
        cmd_acc   = cmd_valid && cmd_ready;
        op        = cmd_op_t'(cmd_op);
    end

    // Next-state, drain counter load/decrement and soft-reset request.
    always_comb begin
        state_nxt      = state;
        drain_nxt      = drain_cnt;
        pipe_reset_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (op)
                        CMD_RUN:  state_nxt = ST_RUN;
                        CMD_STEP: state_nxt = ST_STEP;
                        CMD_HALT: pipe_reset_nxt = 1'b1;
                        default:  state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // Halt word and HALT command together still load the counter once.
                if (hit || (cmd_acc && (op == CMD_HALT))) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end
            end
            ST_STEP: begin
                if (hit) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_nxt = drain_cnt - DW'(1);
                end
            end
            ST_HALTED: begin
                if (cmd_acc && (op == CMD_HALT)) begin
                    state_nxt      = ST_IDLE;
                    pipe_reset_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and drain counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Status outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_reset <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            pipe_reset <= pipe_reset_nxt;
            busy       <= is_enabled_state(state_nxt);
            halted     <= (state_nxt == ST_HALTED);
            done_pulse <= (state_nxt == ST_HALTED) && (state != ST_HALTED);
        end
    end

    sat_counter #(
        .W(CYCLE_W)
    ) u_cycle_count (
        .clk  (clk),
        .reset(reset),
        .clr  (pipe_reset_nxt),
        .inc  (pipe_en),
        .q    (cycle_count)
    );

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Bench for pipeline_exec_ctrl: two instances (default parameters, and a
// 4-bit counter with a single drain cycle) share stimulus and are compared
// every cycle against a behavioural model, plus directed scenario checks.
module tb_pipeline_exec_ctrl;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;
    localparam logic [31:0] HALT_W = 32'hFC00_1234;

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    logic cmd_valid;
    logic [1:0] cmd_op;
    logic [31:0] instr_IF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic cmd_ready_a, pipe_en_a, pc_en_a, pipe_reset_a, busy_a, halted_a, done_pulse_a;
    logic [31:0] cycle_count_a;
    logic [2:0] dbg_state_a;
    logic cmd_ready_b, pipe_en_b, pc_en_b, pipe_reset_b, busy_b, halted_b, done_pulse_b;
    logic [3:0] cycle_count_b;
    logic [2:0] dbg_state_b;

    pipeline_exec_ctrl u_dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
        .cmd_op(cmd_op), .instr_IF(instr_IF), .pipe_en(pipe_en_a), .pc_en(pc_en_a),
        .pipe_reset(pipe_reset_a), .busy(busy_a), .halted(halted_a),
        .done_pulse(done_pulse_a), .cycle_count(cycle_count_a), .dbg_state(dbg_state_a)
    );

    pipeline_exec_ctrl #(.CYCLE_W(4), .DRAIN_CYCLES(1)) u_dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
        .cmd_op(cmd_op), .instr_IF(instr_IF), .pipe_en(pipe_en_b), .pc_en(pc_en_b),
        .pipe_reset(pipe_reset_b), .busy(busy_b), .halted(halted_b),
        .done_pulse(done_pulse_b), .cycle_count(cycle_count_b), .dbg_state(dbg_state_b)
    );

    // ---------------- scoreboard / model ----------------
    int errors = 0;
    int checks = 0;

    int     m_mode [2];
    int     m_left [2];
    bit     m_prst [2];
    bit     m_done [2];
    longint m_cnt  [2];
    longint cmax   [2];
    int     dcyc   [2];
    string  nm     [2];

    int done_cnt [2];
    logic last_pc_en_a, last_pipe_en_a;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if (r[31:26] == 6'h3F) r[26] = 1'b0;
        return r;
    endfunction

    function automatic bit model_enabled(input int i);
        return (m_mode[i] == M_RUN) || (m_mode[i] == M_STEP) || (m_mode[i] == M_DRAIN);
    endfunction

    function automatic bit model_ready(input int i);
        return (m_mode[i] == M_IDLE) || (m_mode[i] == M_RUN) || (m_mode[i] == M_HALTED);
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic o_pe, o_pc, o_rdy, o_pr, o_busy, o_h, o_d;
            logic [63:0] o_cnt;
            bit hit;
            if (i == 0) begin
                o_pe = pipe_en_a; o_pc = pc_en_a; o_rdy = cmd_ready_a; o_pr = pipe_reset_a;
                o_busy = busy_a; o_h = halted_a; o_d = done_pulse_a; o_cnt = 64'(cycle_count_a);
            end else begin
                o_pe = pipe_en_b; o_pc = pc_en_b; o_rdy = cmd_ready_b; o_pr = pipe_reset_b;
                o_busy = busy_b; o_h = halted_b; o_d = done_pulse_b; o_cnt = 64'(cycle_count_b);
            end
            hit = (instr_IF[31:26] == 6'h3F);
            check({nm[i], ".pipe_en"},     64'(o_pe),   64'(model_enabled(i)));
            check({nm[i], ".pc_en"},       64'(o_pc),   64'(model_enabled(i) && !hit && m_mode[i] != M_DRAIN));
            check({nm[i], ".cmd_ready"},   64'(o_rdy),  64'(model_ready(i)));
            check({nm[i], ".pipe_reset"},  64'(o_pr),   64'(m_prst[i]));
            check({nm[i], ".busy"},        64'(o_busy), 64'(model_enabled(i)));
            check({nm[i], ".halted"},      64'(o_h),    64'(m_mode[i] == M_HALTED));
            check({nm[i], ".done_pulse"},  64'(o_d),    64'(m_done[i]));
            check({nm[i], ".cycle_count"}, o_cnt,       64'(m_cnt[i]));
        end
    endtask

    task automatic model_update(input bit rst, input bit v, input logic [1:0] op, input logic [31:0] instr);
        for (int i = 0; i < 2; i++) begin
            bit acc, hit;
            if (rst) begin
                m_mode[i] = M_IDLE; m_left[i] = 0; m_prst[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
            end else begin
                acc = v && model_ready(i);
                hit = (instr[31:26] == 6'h3F);
                m_prst[i] = 0;
                m_done[i] = 0;
                if (model_enabled(i) && m_cnt[i] < cmax[i]) m_cnt[i]++;
                case (m_mode[i])
                    M_IDLE: if (acc) begin
                        if (op == OP_RUN) m_mode[i] = M_RUN;
                        else if (op == OP_STEP) m_mode[i] = M_STEP;
                        else if (op == OP_HALT) begin m_prst[i] = 1; m_cnt[i] = 0; end
                    end
                    M_RUN: if (hit || (acc && op == OP_HALT)) begin
                        m_mode[i] = M_DRAIN; m_left[i] = dcyc[i];
                    end
                    M_STEP: if (hit) begin
                        m_mode[i] = M_DRAIN; m_left[i] = dcyc[i];
                    end else m_mode[i] = M_IDLE;
                    M_DRAIN: begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin m_mode[i] = M_HALTED; m_done[i] = 1; end
                    end
                    M_HALTED: if (acc && op == OP_HALT) begin
                        m_mode[i] = M_IDLE; m_prst[i] = 1; m_cnt[i] = 0;
                    end
                    default: m_mode[i] = M_IDLE;
                endcase
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step_cycle(input bit rst, input bit v, input logic [1:0] op, input logic [31:0] instr);
        @(negedge clk);
        reset = rst; cmd_valid = v; cmd_op = op; instr_IF = instr;
        #1;
        compare_all();
        last_pc_en_a = pc_en_a;
        last_pipe_en_a = pipe_en_a;
        if (done_pulse_a) done_cnt[0]++;
        if (done_pulse_b) done_cnt[1]++;
        @(posedge clk);
        model_update(rst, v, op, instr);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) step_cycle(1'b0, 1'b0, OP_NOP, rand_instr());
    endtask

    task automatic do_reset();
        step_cycle(1'b1, 1'b0, OP_NOP, rand_instr());
        step_cycle(1'b1, 1'b0, OP_NOP, rand_instr());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nm[0] = "a"; nm[1] = "b";
        cmax[0] = 64'hFFFF_FFFF; cmax[1] = 15;
        dcyc[0] = 4; dcyc[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_left[i] = 0; m_prst[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
        end
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; instr_IF = 32'h0;

        // 1: reset held two cycles then released
        do_reset();
        check("t1.pipe_en", 64'(pipe_en_a), 64'd0);
        check("t1.halted", 64'(halted_a), 64'd0);
        check("t1.cycle_count", 64'(cycle_count_a), 64'd0);
        check("t1.cmd_ready", 64'(cmd_ready_a), 64'd1);

        // 2: RUN, halt word on enabled cycle 7
        done_cnt[0] = 0; done_cnt[1] = 0;
        step_cycle(1'b0, 1'b1, OP_RUN, rand_instr());
        for (int k = 1; k <= 7; k++) step_cycle(1'b0, 1'b0, OP_NOP, (k == 7) ? HALT_W : rand_instr());
        check("t2.pc_en_on_halt", 64'(last_pc_en_a), 64'd0);
        idle_n(4);
        check("t2.halted", 64'(halted_a), 64'd1);
        idle_n(3);
        check("t2.done_once_a", 64'(done_cnt[0]), 64'd1);
        check("t2.done_once_b", 64'(done_cnt[1]), 64'd1);
        check("t2.cycle_count", 64'(cycle_count_a), 64'd11);
        check("t2.cycle_count_b", 64'(cycle_count_b), 64'd8);

        // 3: three STEP commands
        do_reset();
        for (int s = 0; s < 3; s++) begin
            step_cycle(1'b0, 1'b1, OP_STEP, rand_instr());
            step_cycle(1'b0, 1'b0, OP_NOP, rand_instr());
            check("t3.step_enabled", 64'(last_pipe_en_a), 64'd1);
            step_cycle(1'b0, 1'b0, OP_NOP, rand_instr());
            check("t3.back_idle", 64'(last_pipe_en_a), 64'd0);
        end
        check("t3.cycle_count", 64'(cycle_count_a), 64'd3);

        // 4: HALT command and halt word in the same RUN cycle
        do_reset();
        done_cnt[0] = 0;
        step_cycle(1'b0, 1'b1, OP_RUN, rand_instr());
        idle_n(3);
        step_cycle(1'b0, 1'b1, OP_HALT, HALT_W);
        idle_n(7);
        check("t4.done_once", 64'(done_cnt[0]), 64'd1);
        check("t4.cycle_count", 64'(cycle_count_a), 64'd8);
        check("t4.halted", 64'(halted_a), 64'd1);

        // 5: reset in the second DRAIN cycle
        do_reset();
        done_cnt[0] = 0;
        step_cycle(1'b0, 1'b1, OP_RUN, rand_instr());
        idle_n(2);
        step_cycle(1'b0, 1'b0, OP_NOP, HALT_W);
        idle_n(1);
        step_cycle(1'b1, 1'b1, OP_RUN, rand_instr());
        check("t5.pipe_en", 64'(pipe_en_a), 64'd0);
        check("t5.cycle_count", 64'(cycle_count_a), 64'd0);
        check("t5.busy", 64'(busy_a), 64'd0);
        idle_n(6);
        check("t5.no_done", 64'(done_cnt[0]), 64'd0);

        // 6: CLEAR in HALTED, then RUN restarts fetch
        step_cycle(1'b0, 1'b1, OP_RUN, rand_instr());
        step_cycle(1'b0, 1'b0, OP_NOP, HALT_W);
        idle_n(6);
        check("t6.halted_before", 64'(halted_a), 64'd1);
        step_cycle(1'b0, 1'b1, OP_HALT, rand_instr());
        check("t6.pipe_reset", 64'(pipe_reset_a), 64'd1);
        check("t6.halted", 64'(halted_a), 64'd0);
        check("t6.cycle_count", 64'(cycle_count_a), 64'd0);
        step_cycle(1'b0, 1'b1, OP_RUN, rand_instr());
        check("t6.pipe_reset_pulse", 64'(pipe_reset_a), 64'd0);
        step_cycle(1'b0, 1'b0, OP_NOP, rand_instr());
        check("t6.pc_en_restart", 64'(last_pc_en_a), 64'd1);

        // 7: long RUN saturates the narrow counter
        do_reset();
        step_cycle(1'b0, 1'b1, OP_RUN, rand_instr());
        idle_n(20);
        check("t7.count_a", 64'(cycle_count_a), 64'd20);
        check("t7.count_b_sat", 64'(cycle_count_b), 64'd15);
        step_cycle(1'b0, 1'b1, OP_HALT, rand_instr());
        idle_n(6);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit r;
            r = ($urandom_range(0, 79) == 0);
            step_cycle(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 9) == 0) ? HALT_W : rand_instr());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
